// File: rtl/icache.sv
// Direct-mapped instruction cache: 2^INDEX_BITS lines of 16 B, one memory request per line refill.
// Optional hit/miss statistics counters are built when ICACHE_STAT_EN is defined.
module icache #(
   parameter int INDEX_BITS = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         rdy,
   input  logic         rollback,
   input  logic         if_en,
   input  logic [31:0]  if_pc,
   output logic         if_done,
   output logic [31:0]  if_data,
   output logic         mc_en,
   output logic [31:0]  mc_pc,
   input  logic         mc_done,
   input  logic [127:0] mc_data
`ifdef ICACHE_STAT_EN
   ,
   output logic [31:0]  hit_cnt,
   output logic [31:0]  miss_cnt
`endif
);

   localparam int LINES = 1 << INDEX_BITS;
   localparam int TAG_W = 28 - INDEX_BITS;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_REFILL = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   function automatic logic [31:0] sel_word(input logic [127:0] line, input logic [1:0] w);
      case (w)
         2'd0:    sel_word = line[31:0];
         2'd1:    sel_word = line[63:32];
         2'd2:    sel_word = line[95:64];
         default: sel_word = line[127:96];
      endcase
   endfunction

   state_t              r_state, w_state_nxt;
   logic                r_cancel, w_cancel_nxt;
   logic [31:2]         r_req_pc, w_req_pc_nxt;
   logic                w_if_done_nxt;
   logic [31:0]         w_if_data_nxt;
   logic                w_mc_en_nxt;
   logic [31:0]         w_mc_pc_nxt;

   logic [LINES-1:0]    r_valid;
   logic [TAG_W-1:0]    r_tag  [LINES];
   logic [127:0]        r_data [LINES];

   logic [INDEX_BITS-1:0] w_pc_idx;
   logic [TAG_W-1:0]      w_pc_tag;
   logic [INDEX_BITS-1:0] w_req_idx;
   logic                  w_accept;
   logic                  w_hit;
   logic                  w_fill;
   logic                  w_unused;

   assign w_pc_idx  = if_pc[3+INDEX_BITS:4];
   assign w_pc_tag  = if_pc[31:4+INDEX_BITS];
   assign w_req_idx = r_req_pc[3+INDEX_BITS:4];
   assign w_accept  = (r_state == S_IDLE) && if_en && !if_done && !rollback;
   assign w_hit     = r_valid[w_pc_idx] && (r_tag[w_pc_idx] == w_pc_tag);
   assign w_fill    = (r_state == S_REFILL) && mc_done;
   // Fetch addresses are word aligned; the byte offset carries no information.
   assign w_unused  = &{1'b0, if_pc[1:0]};

   // Next-state and next-output logic.
   always_comb begin
      w_state_nxt   = r_state;
      w_cancel_nxt  = r_cancel;
      w_req_pc_nxt  = r_req_pc;
      w_if_done_nxt = 1'b0;
      w_if_data_nxt = if_data;
      w_mc_en_nxt   = mc_en;
      w_mc_pc_nxt   = mc_pc;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_req_pc_nxt = if_pc[31:2];
               if (w_hit) begin
                  w_if_done_nxt = 1'b1;
                  w_if_data_nxt = sel_word(r_data[w_pc_idx], if_pc[3:2]);
               end else begin
                  w_state_nxt = S_REFILL;
                  w_mc_en_nxt = 1'b1;
                  w_mc_pc_nxt = {if_pc[31:4], 4'b0000};
               end
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_REFILL: begin
            if (rollback) begin
               w_cancel_nxt = 1'b1;
            end else begin
               w_cancel_nxt = r_cancel;
            end
            if (mc_done) begin
               w_mc_en_nxt = 1'b0;
               w_state_nxt = S_RESP;
            end else begin
               w_state_nxt = S_REFILL;
            end
         end
         S_RESP: begin
            // A rollback arriving this cycle also kills the response about to fire.
            if (!r_cancel && !rollback) begin
               w_if_done_nxt = 1'b1;
               w_if_data_nxt = sel_word(r_data[w_req_idx], r_req_pc[3:2]);
            end else begin
               w_if_done_nxt = 1'b0;
            end
            w_cancel_nxt = 1'b0;
            w_state_nxt  = S_IDLE;
         end
         default: begin
            w_state_nxt  = S_IDLE;
            w_cancel_nxt = 1'b0;
         end
      endcase
   end

   // Control state and registered outputs; everything holds while rdy is low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_cancel <= 1'b0;
         r_req_pc <= 30'd0;
         if_done  <= 1'b0;
         if_data  <= 32'd0;
         mc_en    <= 1'b0;
         mc_pc    <= 32'd0;
      end else if (rdy) begin
         r_state  <= w_state_nxt;
         r_cancel <= w_cancel_nxt;
         r_req_pc <= w_req_pc_nxt;
         if_done  <= w_if_done_nxt;
         if_data  <= w_if_data_nxt;
         mc_en    <= w_mc_en_nxt;
         mc_pc    <= w_mc_pc_nxt;
      end
   end

   // Line valid bits; reset invalidates the whole cache.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= '0;
      end else if (rdy && w_fill) begin
         r_valid[w_req_idx] <= 1'b1;
      end
   end

   // Tag and data arrays, written on refill completion.
   always_ff @(posedge clk) begin
      if (rdy && w_fill) begin
         r_tag[w_req_idx]  <= r_req_pc[31:4+INDEX_BITS];
         r_data[w_req_idx] <= mc_data;
      end
   end

`ifdef ICACHE_STAT_EN
   // Hit/miss counters over accepted requests only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_cnt  <= 32'd0;
         miss_cnt <= 32'd0;
      end else if (rdy && w_accept) begin
         if (w_hit) begin
            hit_cnt <= hit_cnt + 32'd1;
         end else begin
            miss_cnt <= miss_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_icache.sv
// Directed testbench for icache: a vector table of fetch requests plus hand-written
// sequences for rollback, rdy stalls, idle mc_done and reset during a refill.
module tb_icache;

   logic         clk = 1'b0;
   logic         rst;
   logic         rdy;
   logic         rollback;
   logic         if_en;
   logic [31:0]  if_pc;
   logic         if_done;
   logic [31:0]  if_data;
   logic         mc_en;
   logic [31:0]  mc_pc;
   logic         mc_done;
   logic [127:0] mc_data;
`ifdef ICACHE_STAT_EN
   logic [31:0]  hit_cnt;
   logic [31:0]  miss_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   icache #(.INDEX_BITS(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .rdy      (rdy),
      .rollback (rollback),
      .if_en    (if_en),
      .if_pc    (if_pc),
      .if_done  (if_done),
      .if_data  (if_data),
      .mc_en    (mc_en),
      .mc_pc    (mc_pc),
      .mc_done  (mc_done),
      .mc_data  (mc_data)
`ifdef ICACHE_STAT_EN
      ,
      .hit_cnt  (hit_cnt),
      .miss_cnt (miss_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]  pc;
      logic [127:0] fill;
      logic         miss;
      logic [31:0]  mcpc;
      logic [31:0]  data;
   } vec_t;

   localparam logic [127:0] L0 = 128'h44444444_33333333_22222222_11111111;
   localparam logic [127:0] L1 = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
   localparam logic [127:0] L2 = 128'h0F0F0F0F_E0E0E0E0_12345678_9ABCDEF0;
   localparam logic [127:0] L3 = 128'h87654321_0BADF00D_CAFEBABE_DEADBEEF;
   localparam logic [127:0] L4 = 128'h4444AAAA_3333BBBB_2222CCCC_1111DDDD;

   vec_t vecs [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One fetch request, serving a refill with v.fill if the cache asks for one.
   task automatic run_req(input vec_t v, input string tag);
      int k;
      if_en = 1'b1;
      if_pc = v.pc;
      step();
      if_en = 1'b0;
      chk({tag, "_mc_en"}, {31'd0, mc_en}, {31'd0, v.miss});
      if (mc_en) begin
         chk({tag, "_mc_pc"}, mc_pc, v.mcpc);
         mc_data = v.fill;
         mc_done = 1'b1;
         step();
         mc_done = 1'b0;
         chk({tag, "_mc_en_drop"}, {31'd0, mc_en}, 32'd0);
         k = 0;
         while (!if_done && k < 4) begin
            step();
            k++;
         end
      end
      chk({tag, "_if_done"}, {31'd0, if_done}, 32'd1);
      chk({tag, "_if_data"}, if_data, v.data);
      step();
      chk({tag, "_if_done_pulse"}, {31'd0, if_done}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected test end");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic seen;
      vecs[0] = '{32'h0000_0014, L0, 1'b1, 32'h0000_0010, 32'h2222_2222};
      vecs[1] = '{32'h0000_0018, L0, 1'b0, 32'h0000_0000, 32'h3333_3333};
      vecs[2] = '{32'h0000_0010, L0, 1'b0, 32'h0000_0000, 32'h1111_1111};
      vecs[3] = '{32'h0000_001C, L0, 1'b0, 32'h0000_0000, 32'h4444_4444};
      vecs[4] = '{32'h0000_0114, L1, 1'b1, 32'h0000_0110, 32'hBBBB_BBBB};
      vecs[5] = '{32'h0000_0014, L0, 1'b1, 32'h0000_0010, 32'h2222_2222};
      vecs[6] = '{32'hFFFF_FFF0, L2, 1'b1, 32'hFFFF_FFF0, 32'h9ABC_DEF0};
      vecs[7] = '{32'hFFFF_FFFC, L2, 1'b0, 32'h0000_0000, 32'h0F0F_0F0F};

      rst = 1'b1; rdy = 1'b1; rollback = 1'b0; if_en = 1'b0;
      if_pc = 32'd0; mc_done = 1'b0; mc_data = 128'd0;
      repeat (2) step();
      rst = 1'b0;
      step();

      // Asynchronous reset pulse in mid-cycle.
      #3 rst = 1'b1;
      #1;
      chk("rst_if_done", {31'd0, if_done}, 32'd0);
      chk("rst_if_data", if_data, 32'd0);
      chk("rst_mc_en", {31'd0, mc_en}, 32'd0);
      chk("rst_mc_pc", mc_pc, 32'd0);
`ifdef ICACHE_STAT_EN
      chk("rst_hit_cnt", hit_cnt, 32'd0);
      chk("rst_miss_cnt", miss_cnt, 32'd0);
`endif
      step();
      rst = 1'b0;
      step();

      for (int i = 0; i < 8; i++) begin
         run_req(vecs[i], $sformatf("vec%0d", i));
      end

      // Rollback during a refill: line installed, response suppressed.
      if_en = 1'b1; if_pc = 32'h0000_0020;
      step();
      if_en = 1'b0;
      chk("rb_mc_en", {31'd0, mc_en}, 32'd1);
      rollback = 1'b1;
      step();
      rollback = 1'b0;
      chk("rb_mc_en_held", {31'd0, mc_en}, 32'd1);
      mc_data = L3; mc_done = 1'b1;
      step();
      mc_done = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         seen = seen | if_done;
      end
      chk("rb_no_if_done", {31'd0, seen}, 32'd0);
      run_req('{32'h0000_0024, L3, 1'b0, 32'h0000_0000, 32'hCAFE_BABE}, "rb_hit");

      // rdy stall during REFILL, during RESP and while if_done is high.
      if_en = 1'b1; if_pc = 32'h0000_0034;
      step();
      if_en = 1'b0;
      chk("stall_mc_en", {31'd0, mc_en}, 32'd1);
      rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("stall_refill_mc_en%0d", i), {31'd0, mc_en}, 32'd1);
         chk($sformatf("stall_refill_mc_pc%0d", i), mc_pc, 32'h0000_0030);
      end
      rdy = 1'b1; mc_data = L4; mc_done = 1'b1;
      step();
      mc_done = 1'b0; rdy = 1'b0;
      chk("stall_mc_en_drop", {31'd0, mc_en}, 32'd0);
      chk("stall_mc_pc_hold", mc_pc, 32'h0000_0030);
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("stall_resp_if_done%0d", i), {31'd0, if_done}, 32'd0);
      end
      rdy = 1'b1;
      step();
      rdy = 1'b0;
      chk("stall_resp_done", {31'd0, if_done}, 32'd1);
      chk("stall_resp_data", if_data, 32'h2222_CCCC);
      for (int i = 0; i < 2; i++) begin
         step();
         chk($sformatf("stall_done_hold%0d", i), {31'd0, if_done}, 32'd1);
      end
      rdy = 1'b1;
      step();
      chk("stall_done_clear", {31'd0, if_done}, 32'd0);
      step();
      chk("stall_no_dup", {31'd0, if_done}, 32'd0);

      // Rollback blocks acceptance of a would-be hit.
      if_en = 1'b1; if_pc = 32'h0000_0018; rollback = 1'b1;
      step();
      if_en = 1'b0; rollback = 1'b0;
      chk("rbidle_if_done", {31'd0, if_done}, 32'd0);
      chk("rbidle_mc_en", {31'd0, mc_en}, 32'd0);
      step();

      // Stray mc_done in IDLE is ignored.
      mc_data = {128{1'b1}}; mc_done = 1'b1;
      step();
      mc_done = 1'b0;
      chk("idle_mcdone_mc_en", {31'd0, mc_en}, 32'd0);
      run_req('{32'h0000_0014, L0, 1'b0, 32'h0000_0000, 32'h2222_2222}, "idle_mcdone_hit");

`ifdef ICACHE_STAT_EN
      chk("hit_cnt", hit_cnt, 32'd6);
      chk("miss_cnt", miss_cnt, 32'd6);
`endif

      // Reset in the middle of a refill drops mc_en at once and invalidates everything.
      if_en = 1'b1; if_pc = 32'h0000_0040;
      step();
      if_en = 1'b0;
      chk("rstmid_mc_en", {31'd0, mc_en}, 32'd1);
      #3 rst = 1'b1;
      #1;
      chk("rstmid_mc_en_drop", {31'd0, mc_en}, 32'd0);
      step();
      rst = 1'b0;
      step();
      run_req('{32'h0000_0018, L0, 1'b1, 32'h0000_0010, 32'h3333_3333}, "post_rst");
`ifdef ICACHE_STAT_EN
      chk("post_rst_miss_cnt", miss_cnt, 32'd1);
      chk("post_rst_hit_cnt", hit_cnt, 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/icache.md
# icache

Direct-mapped instruction cache between the instruction fetch unit and the memory controller's instruction port. It serves 32-bit instruction words to fetch, returning hits one cycle after acceptance. On a miss it refills a full 16-byte line through a single memory-controller request. Branch-misprediction rollback cancels a pending response, but any refill already in progress runs to completion.

## Interface
- INDEX_BITS, 4, log2 of the line count (default 16 lines × 16 B); the tag is pc[31:4+INDEX_BITS].

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- rdy  in  1  global ready; when 0, all state and outputs hold
- rollback  in  1  misprediction flush from the ROB
- if_en  in  1  fetch request (level)
- if_pc  in  32  fetch address; pc[1:0] must be 0
- if_done  out  1  one-cycle response strobe
- if_data  out  32  instruction word; valid while if_done=1
- mc_en  out  1  refill request to the memory controller; held until mc_done
- mc_pc  out  32  line base address, {pc[31:4],4'b0}
- mc_done  in  1  refill complete (one-cycle pulse)
- mc_data  in  128  line data; word k = mc_data[32k+31:32k], little-endian
- hit_cnt  out  32  hit count; present only with ICACHE_STAT_EN
- miss_cnt  out  32  miss count; present only with ICACHE_STAT_EN

## Operation
- Address fields:
  - offset: word = pc[3:2]
  - index = pc[3+INDEX_BITS:4]
  - tag = pc[31:4+INDEX_BITS]
- Per-line storage: valid bit, tag, 128-bit data.
- States:
  - IDLE: waiting for a request.
  - REFILL: miss outstanding at the memory controller.
  - RESP: one-cycle response after a refill.
- Request acceptance: a request is accepted only when all of the following hold:
  - state = IDLE
  - if_en = 1
  - if_done = 0 in the same cycle
  - rollback = 0
- Accepting a request latches pc into req_pc.
- Hit (valid && tag match): state stays IDLE. Next cycle, if_done=1 and if_data=word. hit_cnt increments.
- Miss: state goes to REFILL. Next cycle, mc_en=1 and mc_pc=line base. miss_cnt increments.
- REFILL with mc_done=1:
  - Write data, tag and valid for the line at req_pc's index.
  - Drop mc_en.
  - Go to RESP.
- RESP:
  - Assert if_done=1 with the requested word, unless the request was cancelled.
  - Clear the cancel flag and return to IDLE.
- Rollback while in REFILL or RESP: sets the cancel flag.
  - The refill still completes and the line is still installed.
  - if_done is suppressed for the cancelled request.
- Rollback in the cycle a hit is accepted would conflict with acceptance, so no request is accepted that cycle. A rollback asserted in the cycle before an if_done would fire suppresses that if_done.
- There is no store-to-instruction coherence; self-modifying code is unsupported.

## Timing
- Reset values:
  - if_done=0, if_data=0, mc_en=0, mc_pc=0
  - state=IDLE, cancel=0
  - all valid bits=0; counters=0
- Reset mid-refill aborts immediately: mc_en drops asynchronously and the line is not installed.
- Hit latency: 1 cycle from acceptance to if_done.
- Maximum hit throughput: one per 2 cycles. if_en may stay high, but no request is accepted while if_done=1.
- Miss latency: 1 cycle to mc_en, plus memory-controller time, plus 1 cycle (RESP) after mc_done.
- mc_en and mc_pc are registered and stable from assertion until the cycle after mc_done.
- mc_done while in IDLE is ignored.
- rdy=0: nothing advances. Pulses are extended; if_done holds its value.
- Index wrap: addresses differing only in tag map to the same line; the newest fill replaces the old line.

## Configuration
- ICACHE_STAT_EN defined:
  - hit_cnt and miss_cnt ports and registers exist.
  - Counters are 32-bit, wrap at 2^32, and count accepted requests only.
  - Counting is unaffected by rollback.
- ICACHE_STAT_EN undefined: the ports and counters are absent. All other behaviour is identical.

## Test plan
- Reset: pulse rst asynchronously mid-cycle. Expect all outputs 0; any subsequent request to any address misses.
- Cold miss: if_pc=0x00000014, then mc_done with mc_data=0x44444444_33333333_22222222_11111111. Expect:
  - mc_pc=0x00000010
  - if_done one cycle after mc_done, with if_data=0x22222222
  - miss_cnt=1
- Hit: after the cold miss, if_pc=0x00000018. Expect if_done 1 cycle after acceptance, if_data=0x33333333, mc_en never asserted, hit_cnt=1.
- Conflict: if_pc=0x00000114 (same index 1, different tag) refills with mc_pc=0x00000110. A following request to 0x14 then misses again.
- Rollback mid-refill: miss at 0x00000020, rollback while mc_en=1, then mc_done. Expect no if_done. A later request to 0x24 then hits.
- rdy stall: drop rdy for 3 cycles during REFILL and during RESP. Expect mc_en, mc_pc and if_done frozen, with no duplicate or lost response.
